// File: rtl/sector_stream_formatter.sv
`timescale 1ns/1ps
// Sector image formatter: preamble, sync, fixed-length payload, optional CRC-16/CCITT-FALSE, postamble.
// Define SECTOR_STREAM_FORMATTER_CRC_EN to include the CRC_HI/CRC_LO bytes and the CRC logic.
module sector_stream_formatter #(
   parameter int unsigned PREAMBLE_LEN  = 13,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA1,
   parameter int unsigned PAYLOAD_LEN   = 512,
   parameter int unsigned POSTAMBLE_LEN = 3
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic        enable,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic [7:0]  s_tdata,
   input  logic        s_tlast,
   input  logic [7:0]  s_tid,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic [7:0]  m_tdata,
   output logic        m_tlast,
   output logic [7:0]  m_tid,
   output logic        busy,
   output logic        short_frame,
   output logic        long_frame,
   input  logic        err_clear,
   output logic [15:0] frame_count
);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SYNC,
      ST_PAYLOAD,
      ST_PAD,
      ST_DRAIN,
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
      ST_CRC_HI,
      ST_CRC_LO,
`endif
      ST_POSTAMBLE
   } state_t;

`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
   localparam state_t ST_AFTER_DATA = ST_CRC_HI;
`else
   localparam state_t ST_AFTER_DATA = ST_POSTAMBLE;
`endif

   localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0] PAY_LAST  = 16'(PAYLOAD_LEN - 1);
   localparam logic [15:0] POST_LAST = 16'(POSTAMBLE_LEN - 1);
   localparam logic [15:0] POST_DONE = 16'(POSTAMBLE_LEN);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        m_tvalid_q, m_tvalid_d;
   logic [7:0]  m_tdata_q, m_tdata_d;
   logic        m_tlast_q, m_tlast_d;
   logic [7:0]  m_tid_q, m_tid_d;
   logic        short_q, short_d;
   logic        long_q, long_d;
   logic [15:0] fc_q, fc_d;
   logic        slot_free;
   logic        s_tready_c;

`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
   logic [15:0] crc_q, crc_d;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
      logic [15:0] c;
      logic [7:0]  d;
      logic        fb;
      c = crc_in;
      d = data;
      for (int unsigned i = 0; i < 8; i++) begin
         fb = c[15] ^ d[7];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         d  = {d[6:0], 1'b0};
      end
      return c;
   endfunction
`endif

   assign slot_free = !m_tvalid_q || m_tready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      m_tvalid_d = m_tvalid_q;
      m_tdata_d  = m_tdata_q;
      m_tlast_d  = m_tlast_q;
      m_tid_d    = m_tid_q;
      short_d    = err_clear ? 1'b0 : short_q;
      long_d     = err_clear ? 1'b0 : long_q;
      fc_d       = fc_q;
      s_tready_c = 1'b0;
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
      crc_d      = crc_q;
`endif
      // A free slot empties the output stage unless a state below reloads it.
      if (slot_free) begin
         m_tvalid_d = 1'b0;
         m_tlast_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable && s_tvalid) begin
               m_tid_d = s_tid;
               cnt_d   = '0;
               state_d = ST_PREAMBLE;
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
               crc_d   = 16'hFFFF;
`endif
            end
         end
         ST_PREAMBLE: begin
            if (slot_free) begin
               m_tvalid_d = 1'b1;
               m_tdata_d  = 8'h00;
               if (cnt_q == PRE_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_SYNC;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         ST_SYNC: begin
            if (slot_free) begin
               m_tvalid_d = 1'b1;
               m_tdata_d  = SYNC_BYTE;
               cnt_d      = '0;
               state_d    = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            s_tready_c = slot_free;
            if (slot_free && s_tvalid) begin
               m_tvalid_d = 1'b1;
               m_tdata_d  = s_tdata;
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
               crc_d      = crc16_byte(crc_q, s_tdata);
`endif
               if (cnt_q == PAY_LAST) begin
                  cnt_d = '0;
                  if (s_tlast) begin
                     state_d = ST_AFTER_DATA;
                  end else begin
                     long_d  = 1'b1;
                     state_d = ST_DRAIN;
                  end
               end else if (s_tlast) begin
                  // PAD continues the payload position so it knows how many zeros remain.
                  short_d = 1'b1;
                  cnt_d   = cnt_q + 16'd1;
                  state_d = ST_PAD;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         ST_PAD: begin
            if (slot_free) begin
               m_tvalid_d = 1'b1;
               m_tdata_d  = 8'h00;
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
               crc_d      = crc16_byte(crc_q, 8'h00);
`endif
               if (cnt_q == PAY_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_AFTER_DATA;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         ST_DRAIN: begin
            s_tready_c = 1'b1;
            if (s_tvalid && s_tlast) begin
               cnt_d   = '0;
               state_d = ST_AFTER_DATA;
            end
         end
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
         ST_CRC_HI: begin
            if (slot_free) begin
               m_tvalid_d = 1'b1;
               m_tdata_d  = crc_q[15:8];
               cnt_d      = '0;
               state_d    = ST_CRC_LO;
            end
         end
         ST_CRC_LO: begin
            if (slot_free) begin
               m_tvalid_d = 1'b1;
               m_tdata_d  = crc_q[7:0];
               cnt_d      = '0;
               state_d    = ST_POSTAMBLE;
            end
         end
`endif
         ST_POSTAMBLE: begin
            // Stay here after loading the tlast byte until it is actually accepted.
            if (slot_free) begin
               if (cnt_q == POST_DONE) begin
                  fc_d    = fc_q + 16'd1;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  m_tvalid_d = 1'b1;
                  m_tdata_d  = 8'h00;
                  m_tlast_d  = (cnt_q == POST_LAST);
                  cnt_d      = cnt_q + 16'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tlast_q  <= 1'b0;
         m_tid_q    <= '0;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
         fc_q       <= '0;
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
         crc_q      <= '1;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tlast_q  <= m_tlast_d;
         m_tid_q    <= m_tid_d;
         short_q    <= short_d;
         long_q     <= long_d;
         fc_q       <= fc_d;
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
         crc_q      <= crc_d;
`endif
      end
   end

   assign s_tready    = s_tready_c;
   assign m_tvalid    = m_tvalid_q;
   assign m_tdata     = m_tdata_q;
   assign m_tlast     = m_tlast_q;
   assign m_tid       = m_tid_q;
   assign busy        = (state_q != ST_IDLE);
   assign short_frame = short_q;
   assign long_frame  = long_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_sector_stream_formatter.sv
`timescale 1ns/1ps
// Directed bench for sector_stream_formatter with a 9-byte payload; expectations follow
// SECTOR_STREAM_FORMATTER_CRC_EN the same way the design does.
module tb_sector_stream_formatter;

   localparam int unsigned PRE  = 13;
   localparam int unsigned PAY  = 9;
   localparam int unsigned POST = 3;
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
   localparam int unsigned IMG_LEN = 28;
`else
   localparam int unsigned IMG_LEN = 26;
`endif
   localparam int unsigned TMO = 2000;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        enable = 1'b0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [7:0]  s_tdata = '0;
   logic        s_tlast = 1'b0;
   logic [7:0]  s_tid = '0;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic [7:0]  m_tdata;
   logic        m_tlast;
   logic [7:0]  m_tid;
   logic        busy;
   logic        short_frame;
   logic        long_frame;
   logic        err_clear = 1'b0;
   logic [15:0] frame_count;

   sector_stream_formatter #(
      .PREAMBLE_LEN (PRE),
      .SYNC_BYTE    (8'hA1),
      .PAYLOAD_LEN  (PAY),
      .POSTAMBLE_LEN(POST)
   ) dut (
      .aclk        (aclk),
      .areset      (areset),
      .enable      (enable),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tdata     (s_tdata),
      .s_tlast     (s_tlast),
      .s_tid       (s_tid),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tdata     (m_tdata),
      .m_tlast     (m_tlast),
      .m_tid       (m_tid),
      .busy        (busy),
      .short_frame (short_frame),
      .long_frame  (long_frame),
      .err_clear   (err_clear),
      .frame_count (frame_count)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      int unsigned n;
      logic [7:0]  tid;
      bit          ascii;
      bit          bp;
      bit          pre_clr;
      bit          clr_last;
      bit          exp_short;
      bit          exp_long;
   } vec_t;

   vec_t vecs[10];

   int errors = 0;
   int checks = 0;

   logic [7:0] cap_data[$];
   logic       cap_last[$];
   logic [7:0] cap_tid[$];
   logic [7:0] exp_q[$];

   bit         bp_mode = 1'b0;
   logic       prev_stall = 1'b0;
   logic [7:0] pd, pt;
   logic       pl;
   int         stall_seen = 0;
   int         stall_viol = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pay_byte(input int unsigned i, input logic [7:0] tid, input bit ascii);
      if (ascii) return 8'(32'h31 + i);
      return tid ^ 8'(i * 37 + 1);
   endfunction

`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
   function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction
`endif

   task automatic build_exp(input int unsigned n, input logic [7:0] tid, input bit ascii);
      logic [7:0] b;
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
      logic [15:0] crc;
      crc = 16'hFFFF;
`endif
      exp_q.delete();
      repeat (PRE) exp_q.push_back(8'h00);
      exp_q.push_back(8'hA1);
      for (int unsigned i = 0; i < PAY; i++) begin
         b = (i < n) ? pay_byte(i, tid, ascii) : 8'h00;
         exp_q.push_back(b);
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
         crc = crc_model(crc, b);
`endif
      end
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
      exp_q.push_back(crc[15:8]);
      exp_q.push_back(crc[7:0]);
`endif
      repeat (POST) exp_q.push_back(8'h00);
   endtask

   // Output capture and stall-stability monitor, sampled mid-cycle.
   always @(negedge aclk) begin
      if (areset) begin
         prev_stall = 1'b0;
      end else begin
         if (m_tvalid && m_tready) begin
            cap_data.push_back(m_tdata);
            cap_last.push_back(m_tlast);
            cap_tid.push_back(m_tid);
         end
         if (prev_stall) begin
            stall_seen++;
            if (!(m_tvalid && m_tdata == pd && m_tlast == pl && m_tid == pt)) stall_viol++;
         end
         prev_stall = m_tvalid && !m_tready;
         pd = m_tdata;
         pl = m_tlast;
         pt = m_tid;
      end
   end

   always @(posedge aclk) begin
      #1;
      m_tready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
   end

   task automatic send(input int unsigned n, input logic [7:0] tid, input bit ascii,
                       input bit clr_last, input int unsigned stop_at);
      int unsigned w;
      for (int unsigned i = 0; i < n; i++) begin
         if (stop_at != 0 && i == stop_at) return;
         s_tvalid = 1'b1;
         s_tdata  = pay_byte(i, tid, ascii);
         s_tlast  = (i == n - 1);
         if (i == 0) s_tid = tid;
         if (clr_last && i == n - 1) err_clear = 1'b1;
         w = 0;
         @(negedge aclk);
         while (!s_tready && w < TMO) begin
            w++;
            @(negedge aclk);
         end
         if (!s_tready) begin
            check("s_tready_wait", s_tready, 1);
            s_tvalid = 1'b0;
            err_clear = 1'b0;
            return;
         end
         @(posedge aclk);
         #1;
         err_clear = 1'b0;
         // Later bytes carry a different tag and enable drops mid-sector; neither may matter.
         s_tid = ~tid;
         enable = 1'b0;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_frame(input int fc_before);
      int unsigned w;
      w = 0;
      @(negedge aclk);
      while (frame_count == 16'(fc_before) && w < TMO) begin
         w++;
         @(negedge aclk);
      end
      check("frame_count", frame_count, 16'(fc_before + 1));
   endtask

   task automatic run_row(input vec_t v, input string tag);
      int fc_before;
      int bad, tl_bad, tid_bad;
      enable = 1'b1;
      if (v.pre_clr) begin
         err_clear = 1'b1;
         @(posedge aclk);
         #1;
         err_clear = 1'b0;
      end
      cap_data.delete();
      cap_last.delete();
      cap_tid.delete();
      build_exp(v.n, v.tid, v.ascii);
      fc_before = int'(frame_count);
      bp_mode = v.bp;
      send(v.n, v.tid, v.ascii, v.clr_last, 0);
      wait_frame(fc_before);
      bp_mode = 1'b0;
      @(posedge aclk);
      #1;
      check({tag, "_len"}, cap_data.size(), IMG_LEN);
      bad = 0;
      tl_bad = 0;
      tid_bad = 0;
      foreach (cap_data[i]) begin
         if (i >= exp_q.size() || cap_data[i] !== exp_q[i]) bad++;
         if (cap_last[i] !== (i == cap_data.size() - 1)) tl_bad++;
         if (cap_tid[i] !== v.tid) tid_bad++;
      end
      check({tag, "_data_mismatches"}, bad, 0);
      check({tag, "_tlast_misplaced"}, tl_bad, 0);
      check({tag, "_tid_mismatches"}, tid_bad, 0);
      check({tag, "_short_frame"}, short_frame, v.exp_short);
      check({tag, "_long_frame"}, long_frame, v.exp_long);
      check({tag, "_busy_after"}, busy, 0);
`ifdef SECTOR_STREAM_FORMATTER_CRC_EN
      if (v.ascii && cap_data.size() >= 25) begin
         check({tag, "_crc_hi"}, cap_data[23], 8'h29);
         check({tag, "_crc_lo"}, cap_data[24], 8'hB1);
      end
`endif
   endtask

   initial begin
      int viol;
      vecs[0] = '{9,  8'h05, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4,  8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{12, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{9,  8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{9,  8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{9,  8'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{9,  8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1,  8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{10, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{9,  8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

      repeat (3) @(posedge aclk);
      #1;
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tid", m_tid, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_busy", busy, 0);
      check("rst_short", short_frame, 0);
      check("rst_long", long_frame, 0);
      check("rst_frame_count", frame_count, 0);
      areset = 1'b0;

      enable = 1'b0;
      s_tvalid = 1'b1;
      s_tdata = 8'h55;
      s_tid = 8'h99;
      viol = 0;
      repeat (20) begin
         @(negedge aclk);
         if (busy || s_tready || m_tvalid) viol++;
      end
      check("enable_low_idle", viol, 0);
      @(posedge aclk);
      #1;
      s_tvalid = 1'b0;

      for (int r = 0; r < 10; r++) run_row(vecs[r], $sformatf("row%0d", r));

      check("stall_hold_violations", stall_viol, 0);
      check("stalls_seen", stall_seen > 0, 1);

      // Reset while the fifth payload byte sits in the output stage.
      enable = 1'b1;
      send(9, 8'h66, 1'b0, 1'b0, 5);
      check("pre_reset_busy", busy, 1);
      areset = 1'b1;
      s_tvalid = 1'b0;
      @(posedge aclk);
      #1;
      check("midrst_m_tvalid", m_tvalid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_s_tready", s_tready, 0);
      check("midrst_frame_count", frame_count, 0);
      areset = 1'b0;
      run_row(vecs[0], "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
